// File: rtl/mul4bit_seq_if.sv
// Operand/result bundle for the sequential 4x4 multiplier.
// The master drives the request and operands; the slave returns the
// registered product, status strobes and ALU flags.
interface mul4bit_seq_if;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] Product;
    logic       busy;
    logic       done;
    logic       Overflow;
    logic       Zero;

    modport master (
        output start, A, B,
        input  Product, busy, done, Overflow, Zero
    );

    modport slave (
        input  start, A, B,
        output Product, busy, done, Overflow, Zero
    );
endinterface

// File: rtl/mul4bit_seq.sv
// Sequential 4-bit unsigned shift-and-add multiplier.
// Four add/shift steps per operation, constant latency, one-cycle done
// strobe. Product and flags are registered and change only on completion.
module mul4bit_seq (
    input  logic         clk,
    input  logic         rst_n,
    mul4bit_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] mcand_q, mcand_d;
    logic [3:0] mplier_q, mplier_d;
    logic [7:0] acc_q, acc_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] product_q, product_d;
    logic       overflow_q, overflow_d;
    logic       zero_q, zero_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] acc_sum;

    // Next-state, datapath step and registered-output decode
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        // Max 15*15 = 225, so the 8-bit sum never carries out
        acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    mcand_d  = {4'b0000, bus.A};
                    mplier_d = bus.B;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = {mcand_q[6:0], 1'b0};
                mplier_d = {1'b0, mplier_q[3:1]};
                cnt_d    = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    // The last step's sum is the result; capture it directly
                    product_d  = acc_sum;
                    overflow_d = |acc_sum[7:4];
                    zero_d     = (acc_sum == 8'h00);
                    state_d    = DONE;
                    done_d     = 1'b1;
                end else begin
                    busy_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.Product  = product_q;
    assign bus.Overflow = overflow_q;
    assign bus.Zero     = zero_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
